// File: rtl/move_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | move_sequencer: unpacks a batch of 4-bit move codes into face turns      |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module move_sequencer #(
    parameter int NUM_SLOTS = 50,
    parameter int CODE_W    = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_SLOTS*CODE_W-1:0] moves,
    input  logic                        new_moves,
    input  logic                        move_ready,
    output logic                        move_valid,
    output logic [2:0]                  move_face,
    output logic                        move_dir,
    output logic                        busy,
    output logic                        batch_done,
    output logic [5:0]                  moves_issued,
    output logic                        overrun,
    output logic                        bad_code
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state;
    logic [NUM_SLOTS*CODE_W-1:0] buffer;
    logic [IDX_W-1:0]            index;
    logic [CODE_W-1:0]           code;
    logic                        is_turn;
    logic                        is_bad;

    assign code    = buffer[index*CODE_W +: CODE_W];
    assign is_turn = (code >= CODE_W'(2)) && (code <= CODE_W'(13));
    assign is_bad  = (code >= CODE_W'(14));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            buffer       <= '0;
            index        <= LAST_SLOT;
            move_valid   <= 1'b0;
            move_face    <= 3'd0;
            move_dir     <= 1'b0;
            busy         <= 1'b0;
            batch_done   <= 1'b0;
            moves_issued <= 6'd0;
            overrun      <= 1'b0;
            bad_code     <= 1'b0;
        end else begin
            // A load attempt in any non-idle state, DONE included, is dropped.
            if (new_moves && state != IDLE)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (new_moves) begin
                        buffer       <= moves;
                        index        <= LAST_SLOT;
                        moves_issued <= 6'd0;
                        busy         <= 1'b1;
                        state        <= SCAN;
                    end
                end
                SCAN: begin
                    if (is_turn) begin
                        move_face  <= code[3:1] - 3'd1;
                        move_dir   <= code[0];
                        move_valid <= 1'b1;
                        state      <= ISSUE;
                    end else begin
                        if (is_bad)
                            bad_code <= 1'b1;
                        if (index == '0) begin
                            batch_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            index <= index - 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (move_ready) begin
                        move_valid   <= 1'b0;
                        moves_issued <= moves_issued + 6'd1;
                        if (index == '0) begin
                            batch_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            index <= index - 1'b1;
                            state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    batch_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// Randomized self-checking bench for move_sequencer against a slot-list model.
module tb_move_sequencer;

    localparam int NS = 50;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [199:0]  moves;
    logic          new_moves;
    logic          move_ready;
    logic          move_valid;
    logic [2:0]    move_face;
    logic          move_dir;
    logic          busy;
    logic          batch_done;
    logic [5:0]    moves_issued;
    logic          overrun;
    logic          bad_code;

    int checks   = 0;
    int failures = 0;
    bit exp_over = 1'b0;
    bit exp_bad  = 1'b0;

    always #5 clock = ~clock;

    move_sequencer #(.NUM_SLOTS(NS), .CODE_W(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .moves       (moves),
        .new_moves   (new_moves),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move_face   (move_face),
        .move_dir    (move_dir),
        .busy        (busy),
        .batch_done  (batch_done),
        .moves_issued(moves_issued),
        .overrun     (overrun),
        .bad_code    (bad_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},  32'(move_valid),   0);
        check({tag, "_face"},   32'(move_face),    0);
        check({tag, "_dir"},    32'(move_dir),     0);
        check({tag, "_busy"},   32'(busy),         0);
        check({tag, "_done"},   32'(batch_done),   0);
        check({tag, "_issued"}, 32'(moves_issued), 0);
        check({tag, "_over"},   32'(overrun),      0);
        check({tag, "_bad"},    32'(bad_code),     0);
    endtask

    function automatic logic [199:0] rand_bits();
        return 200'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Loads one batch, drives the handshake with stalls in [smin,smax] and
    // compares every turn, the final count and the batch_done timing.
    task automatic run_batch(input logic [199:0] b, input int smin, input int smax, input bit inject);
        int q[$];
        int n_exp;
        int skipped = 0;
        bit found = 1'b0;
        int exp_done = 1 + NS;
        int cyc = 0;
        int stall;
        int wait_cnt = 0;
        int first_valid = -1;
        bit done_seen = 1'b0;
        bit holding = 1'b0;
        logic [2:0] hold_face = 3'd0;
        logic hold_dir = 1'b0;

        for (int k = NS - 1; k >= 0; k--) begin
            int c;
            c = int'(b[4*k +: 4]);
            if (c >= 2 && c <= 13) begin
                q.push_back((c / 2 - 1) * 2 + (c % 2));
                found = 1'b1;
            end else begin
                if (!found) skipped++;
                if (c >= 14) exp_bad = 1'b1;
            end
        end
        n_exp = q.size();
        if (inject) exp_over = 1'b1;

        @(posedge clock); #1;
        moves      = b;
        new_moves  = 1'b1;
        move_ready = 1'($urandom_range(0, 1));
        stall      = $urandom_range(smin, smax);

        while (!done_seen && cyc < 2000) begin
            @(posedge clock); #1;
            cyc++;
            new_moves = inject && (cyc == 3);
            moves     = rand_bits();
            check("busy_high", 32'(busy), 1);
            if (holding && move_valid) begin
                check("hold_face", 32'(move_face), 32'(hold_face));
                check("hold_dir",  32'(move_dir),  32'(hold_dir));
            end
            if (move_valid) begin
                if (first_valid < 0) begin
                    first_valid = cyc;
                    check("first_valid_cycle", cyc, 2 + skipped);
                end
                if (wait_cnt < stall) begin
                    move_ready = 1'b0;
                    wait_cnt++;
                    holding   = 1'b1;
                    hold_face = move_face;
                    hold_dir  = move_dir;
                end else begin
                    move_ready = 1'b1;
                    if (q.size() == 0)
                        check("extra_turn", 1, 0);
                    else
                        check("turn", 32'(move_face) * 2 + 32'(move_dir), q.pop_front());
                    exp_done += 1 + stall;
                    wait_cnt = 0;
                    holding  = 1'b0;
                    stall    = $urandom_range(smin, smax);
                end
            end else begin
                move_ready = 1'($urandom_range(0, 1));
                holding    = 1'b0;
            end
            if (batch_done) begin
                done_seen = 1'b1;
                check("done_cycle",   cyc, exp_done);
                check("issued",       32'(moves_issued), n_exp);
                check("turns_left",   q.size(), 0);
                check("overrun_flag", 32'(overrun), 32'(exp_over));
                check("bad_flag",     32'(bad_code), 32'(exp_bad));
            end
        end
        if (!done_seen) check("batch_timeout", 0, 1);
        new_moves = 1'b0;
        @(posedge clock); #1;
        check("busy_low_after", 32'(busy), 0);
        check("done_one_cycle", 32'(batch_done), 0);
        check("issued_hold",    32'(moves_issued), n_exp);
    endtask

    initial begin
        logic [199:0] b;
        int guard;

        reset_n    = 1'b0;
        moves      = '0;
        new_moves  = 1'b0;
        move_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;

        run_batch(200'h29D62945, 0, 0, 1'b0);
        run_batch(200'h29D62945, 5, 5, 1'b0);
        run_batch(200'h0,        0, 0, 1'b0);
        run_batch(200'h2F4,      0, 2, 1'b0);
        run_batch(200'h29D62945, 0, 1, 1'b1);

        // Reset while a turn is held in ISSUE.
        @(posedge clock); #1;
        moves      = 200'h45;
        new_moves  = 1'b1;
        move_ready = 1'b0;
        @(posedge clock); #1;
        new_moves = 1'b0;
        guard = 0;
        while (!move_valid && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        check("reset_test_valid", 32'(move_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clock); #1;
        reset_n  = 1'b1;
        exp_over = 1'b0;
        exp_bad  = 1'b0;
        run_batch(200'h45, 0, 2, 1'b0);

        for (int n = 0; n < 12; n++) begin
            int lead;
            b = '0;
            lead = $urandom_range(0, 45);
            for (int k = NS - 1 - lead; k >= 0; k--)
                if ($urandom_range(0, 1) == 1)
                    b[4*k +: 4] = 4'($urandom_range(0, 15));
            run_batch(b, 0, 3, 1'($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
